shared_port_arbiter: RTL and testbench
======================================

# shared_port_arbiter

Round-robin arbiter that shares one resource port (bus master slot, memory port, register-file write port) among up to 16 requesters inside the LCPU/SoC fabric. It owns the select input of the parametrized 16:1 data mux that steers the winning requester onto the shared port. It holds the grant for one full transaction, which ends on `done`, on the owner dropping its request, or on a watchdog timeout. Priority rotates past the last winner so that no requester starves.

## Interface
Parameters:
- `NUM`, 4: number of requesters, legal range 2..16.
- `SELW`, 4: select width. Drives the mux `s` input. Requires 2^SELW >= NUM.
- `TIMEOUT`, 255: maximum grant length in cycles before forced release. 0 disables the watchdog.
- `TW`, 8: width of the watchdog counter. Requires 2^TW > TIMEOUT.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, NUM: per-requester request, level-sensitive.
- `done`, input, 1: the shared resource reports that the current transaction is complete. Sampled only in BUSY.
- `gnt`, output, NUM: one-hot grant, registered.
- `sel`, output, SELW: binary index of the current or last owner. Feeds the mux select.
- `busy`, output, 1: high while a grant is outstanding.
- `timeout`, output, 1: one-cycle pulse on a watchdog-forced release.

## Operation
- Reset values (output register state after the reset edge):
  - `gnt`=0, `sel`=0, `busy`=0, `timeout`=0.
  - State = IDLE.
  - Internal pointer `ptr`=NUM-1, so requester 0 has top priority first.
  - Watchdog counter `cnt`=0.
- State IDLE, when `req`!=0:
  - Winner = first set bit of `req` scanning upward from `ptr+1`, wrapping modulo NUM.
  - Load `gnt`=onehot(winner), `sel`=winner, `busy`=1, `cnt`=0; go to BUSY.
- State IDLE, when `req`==0: all registers hold. `sel` keeps the last winner so the mux output stays stable.
- State BUSY, each cycle, checked in this priority order:
  1. Release by completion: `done`=1, or `req[sel]`=0. Then `gnt`=0, `busy`=0, `ptr`=`sel`; go to IDLE. No timeout pulse.
  2. Watchdog expiry: TIMEOUT!=0 and `cnt`==TIMEOUT-1. Perform the same release as above, and set `timeout`=1 for exactly one cycle.
  3. Otherwise: `cnt`=`cnt`+1 and the grant holds.
- `done` sampled while in IDLE is ignored.
- Requests from non-owners have no effect during BUSY.
- `req` bits at index >= NUM do not exist. `sel` never exceeds NUM-1.
- `ptr` wraps from NUM-1 to 0. When exactly one requester is active, the scan lands on it regardless of `ptr`.
- Once set, `ptr` only ever holds a granted index.

## Timing
- Grant latency: `req` seen in IDLE at the cycle-t edge gives `gnt`, `sel`, `busy` valid from t+1.
- Release latency: a release condition at edge t gives `gnt`=0 and `busy`=0 from t+1.
- Minimum one IDLE cycle between grants. The earliest next grant is visible from t+2. Back-to-back throughput is therefore one transaction per (length + 1) cycles.
- Grant length and watchdog:
  - For a grant first visible at cycle g, `done` at cycle g is honoured, giving a 1-cycle transaction.
  - With no `done`, `gnt` drops and `timeout` pulses at cycle g+TIMEOUT.
  - `done` coinciding with the expiry cycle: `done` wins and `timeout` stays 0.
- `rst` mid-transaction: at the next edge all outputs return to their reset values regardless of state. After that, arbitration restarts from requester 0.
- All outputs are registered. No combinational path runs from `req` or `done` to any output.

## Test plan
All scenarios use NUM=4, SELW=4, TIMEOUT=8.

1. **Rotation:** reset, then hold `req`=4'b1111 and pulse `done` on each grant's first cycle. Grants arrive in order 0001, 0010, 0100, 1000, 0001, with `sel`=0,1,2,3,0. Each grant lasts 1 cycle and is followed by 1 IDLE cycle.
2. **Single requester:** hold `req`=4'b0100 with `done` 3 cycles into each grant. `gnt`=0100 and `sel`=2 for 4 cycles, then 1 cycle low, then repeat. `timeout` never asserts.
3. **Watchdog:** `req`=4'b0010 with no `done`. `gnt`=0010 for 8 cycles, then drops with a 1-cycle `timeout` pulse. If `req`=4'b0011 at that point, the next grant goes to requester 0 at +2 cycles.
4. **`done` at expiry:** same stimulus as scenario 3, but `done`=1 on the 8th grant cycle. `gnt` drops and `timeout` stays 0.
5. **Owner abort:** requester 3 granted, then `req[3]` deasserted on grant cycle 2. `gnt`=0 on the next cycle, `timeout`=0, and `ptr` now points at 3, so the next scan starts at 0.
6. **Reset mid-op:** assert `rst` for 1 cycle while `gnt`=1000 in BUSY. The next cycle shows `gnt`=0, `sel`=0, `busy`=0. With `req`=4'b1001 afterwards, requester 0 wins first.

Source files
------------

// File: rtl/shared_port_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-port arbiter.
// The arbiter connects through the slave modport. The requester side and
// the shared resource connect through the master modport.
interface shared_port_arbiter_if #(
  parameter int NUM  = 4,
  parameter int SELW = 4
);
  logic [NUM-1:0]  req;
  logic            done;
  logic [NUM-1:0]  gnt;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            timeout;

  modport master (
    output req, done,
    input  gnt, sel, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, sel, busy, timeout
  );
endinterface

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter for one shared resource port. A grant is held for a
// whole transaction. The transaction ends on done, when the owner drops its
// request, or when the watchdog expires. The search for the next winner
// starts just past the previous owner.
module shared_port_arbiter #(
  parameter int NUM     = 4,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic                 clk,
  input logic                 rst,
  shared_port_arbiter_if.slave bus
);

  if (NUM < 2 || NUM > 16) begin : g_bad_num
    $error("shared_port_arbiter: NUM must be in 2..16");
  end
  if ((2 ** SELW) < NUM) begin : g_bad_selw
    $error("shared_port_arbiter: SELW too narrow for NUM");
  end
  if (TIMEOUT < 0 || (2 ** TW) <= TIMEOUT) begin : g_bad_tw
    $error("shared_port_arbiter: TW too narrow for TIMEOUT");
  end

  localparam bit            WDOG = (TIMEOUT != 0);
  localparam logic [TW-1:0] LAST = WDOG ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [NUM-1:0]  gnt_q, gnt_n;
  logic [SELW-1:0] sel_q, sel_n;
  logic            busy_q, busy_n;
  logic            to_q, to_n;
  logic [SELW-1:0] ptr_q, ptr_n;
  logic [TW-1:0]   cnt_q, cnt_n;

  logic [NUM-1:0]  req;
  logic            found;
  logic [SELW-1:0] win;
  logic [NUM-1:0]  win_oh;
  logic [SELW:0]   cand;
  logic            owner_req;

  assign req = bus.req;

  // gnt is one-hot on the owner throughout BUSY, so masking req with it
  // is the same test as req[sel] and avoids a variable-width index.
  assign owner_req = |(req & gnt_q);

  // Rotating priority scan: candidates ptr+1, ptr+2, ... modulo NUM.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    cand   = '0;
    for (int unsigned j = 0; j < NUM; j++) begin
      cand = {1'b0, ptr_q} + (SELW+1)'(j + 1);
      if (cand >= (SELW+1)'(NUM)) cand = cand - (SELW+1)'(NUM);
      for (int unsigned b = 0; b < NUM; b++) begin
        if (!found && req[b] && (cand == (SELW+1)'(b))) begin
          found = 1'b1;
          win   = SELW'(b);
        end
      end
    end
    for (int unsigned b = 0; b < NUM; b++) begin
      win_oh[b] = (win == SELW'(b));
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    busy_n  = busy_q;
    to_n    = 1'b0;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = win_oh;
          sel_n   = win;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (bus.done || !owner_req) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = sel_q;
          state_n = IDLE;
        end else if (WDOG && (cnt_q == LAST)) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = sel_q;
          to_n    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      to_q   <= 1'b0;
      ptr_q  <= SELW'(NUM - 1);
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      sel_q  <= sel_n;
      busy_q <= busy_n;
      to_q   <= to_n;
      ptr_q  <= ptr_n;
      cnt_q  <= cnt_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Testbench for shared_port_arbiter with NUM=4, SELW=4, TIMEOUT=8.
// Directed scenarios first, then randomized traffic. Every cycle is
// compared against a transaction-level reference model.
module tb_shared_port_arbiter;

  localparam int NUM = 4;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shared_port_arbiter_if #(.NUM(NUM), .SELW(4)) bus ();

  shared_port_arbiter #(
    .NUM(NUM), .SELW(4), .TIMEOUT(TO), .TW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port, who owned it last, and how many
  // cycles the current grant has been visible.
  int m_owner = -1;
  int m_last  = NUM - 1;
  int m_sel   = 0;
  int m_held  = 0;
  int m_to    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NUM; k++) begin
      int c;
      c = (last + k) % NUM;
      if (((r >> c) & 4'd1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model(input logic [3:0] r, input logic d, input logic rs);
    m_to = 0;
    if (rs) begin
      m_owner = -1; m_last = NUM - 1; m_sel = 0; m_held = 0;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = pick(r, m_last);
        m_sel   = m_owner;
        m_held  = 1;
      end
    end else if (d || (((r >> m_owner) & 4'd1) == 0)) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_held == TO) begin
      m_last  = m_owner;
      m_owner = -1;
      m_to    = 1;
    end else begin
      m_held++;
    end
  endtask

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    logic [31:0] eg;
    bus.req = r;
    bus.done = d;
    rst = rs;
    @(posedge clk);
    model(r, d, rs);
    #1;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check("gnt", 32'(bus.gnt), eg);
    check("sel", 32'(bus.sel), 32'(m_sel));
    check("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  initial begin
    logic [3:0] r;
    logic d;
    int dprob;
    bus.req = '0;
    bus.done = 1'b0;

    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);

    // Rotation with done on each grant's first cycle.
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0, 1'b0);
      check("rot_gnt", 32'(bus.gnt), 32'd1 << (i % 4));
      check("rot_sel", 32'(bus.sel), 32'(i % 4));
      step(4'hF, 1'b1, 1'b0);
      check("rot_idle", 32'(bus.busy), 32'd0);
    end

    // Single requester with a 4-cycle transaction.
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        step(4'h4, 1'b0, 1'b0);
        check("single_gnt", 32'(bus.gnt), 32'h4);
      end
      step(4'h4, 1'b1, 1'b0);
      check("single_rel", 32'(bus.gnt), 32'h0);
      check("single_to", 32'(bus.timeout), 32'h0);
    end

    // Watchdog: 8 cycles of grant, then a forced release.
    for (int c = 0; c < TO; c++) begin
      step(4'h2, 1'b0, 1'b0);
      check("wd_hold", 32'(bus.gnt), 32'h2);
    end
    step(4'h2, 1'b0, 1'b0);
    check("wd_rel", 32'(bus.gnt), 32'h0);
    check("wd_pulse", 32'(bus.timeout), 32'h1);
    step(4'h3, 1'b0, 1'b0);
    check("wd_next", 32'(bus.gnt), 32'h1);
    check("wd_pulse_end", 32'(bus.timeout), 32'h0);
    step(4'h3, 1'b1, 1'b0);

    // done on the expiry cycle wins over the watchdog.
    for (int c = 0; c < TO; c++) step(4'h2, 1'b0, 1'b0);
    check("exp_hold", 32'(bus.gnt), 32'h2);
    step(4'h2, 1'b1, 1'b0);
    check("exp_rel", 32'(bus.gnt), 32'h0);
    check("exp_to", 32'(bus.timeout), 32'h0);

    // Owner abort: requester 3 drops its request on grant cycle 2.
    step(4'h8, 1'b0, 1'b0);
    check("abort_gnt", 32'(bus.gnt), 32'h8);
    step(4'h8, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    check("abort_rel", 32'(bus.gnt), 32'h0);
    check("abort_to", 32'(bus.timeout), 32'h0);
    step(4'h9, 1'b0, 1'b0);
    check("abort_next", 32'(bus.gnt), 32'h1);
    step(4'h9, 1'b1, 1'b0);

    // Reset in the middle of a transaction.
    step(4'h8, 1'b0, 1'b0);
    check("rmid_gnt", 32'(bus.gnt), 32'h8);
    step(4'h8, 1'b0, 1'b1);
    check("rmid_rst_gnt", 32'(bus.gnt), 32'h0);
    check("rmid_rst_sel", 32'(bus.sel), 32'h0);
    step(4'h9, 1'b0, 1'b0);
    check("rmid_next", 32'(bus.gnt), 32'h1);
    step(4'h9, 1'b1, 1'b0);

    // Randomized traffic; done rate varies so that watchdog expiry,
    // owner aborts and short transactions all occur.
    r = 4'h0;
    dprob = 4;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 250) == 0) dprob = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 99) < dprob);
      step(r, d, ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
